// File: rtl/cdc_src_holdoff_if.sv
// rtl/cdc_src_holdoff_if.sv - stream-in / held-bus-out bundle for cdc_src_holdoff
//
// Purpose: groups the upstream valid/ready word stream and the held source
//          bus presented to the 64-bit two-flop crossing.
// Signals:
//   in_valid     upstream word valid            (master -> slave)
//   in_data      upstream word, WIDTH bits      (master -> slave)
//   in_ready     slave accepts word this cycle  (slave -> master)
//   hold_data    stable word to crossing input  (slave -> master)
//   busy         slave is holding a word        (slave -> master)
//   launch_count words launched since reset     (slave -> master)
interface cdc_src_holdoff_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] hold_data;
   logic             busy;
   logic [15:0]      launch_count;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  hold_data,
      input  busy,
      input  launch_count
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output hold_data,
      output busy,
      output launch_count
   );
endinterface

// File: rtl/cdc_src_holdoff.sv
// rtl/cdc_src_holdoff.sv - source-side hold-off in front of a multi-bit two-flop crossing
//
// Purpose: accepts words on a valid/ready stream and launches each onto the
//          crossing's source data bus, then refuses new words for HOLD_CYCLES
//          src_clk cycles so the synchroniser never samples a half-updated bus.
//          Back-to-back throughput is one word per HOLD_CYCLES+1 cycles.
// Parameters:
//   WIDTH        data width, equal to the crossing bus width
//   HOLD_CYCLES  cycles spent holding after each launch, 1..255
// Ports:
//   src_clk      source-domain clock
//   src_rst_n    asynchronous active-low reset (release synchronised upstream)
//   bus          cdc_src_holdoff_if.slave: in_valid/in_data in,
//                in_ready/hold_data/busy/launch_count out (all registered)
// Build option:
//   CDC_SRC_HOLD_SKIP_DUP_EN - when defined, a word equal to the value already
//   on hold_data is consumed in IDLE without a new launch or hold period.
module cdc_src_holdoff #(
   parameter int WIDTH       = 64,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                src_clk,
   input  logic                src_rst_n,
   cdc_src_holdoff_if.slave    bus
);

   generate
      if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
         $error("cdc_src_holdoff: HOLD_CYCLES must be within 1..255");
      end
   endgenerate

   localparam logic [7:0] CNT_RELOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state_q,        state_d;
   logic [7:0]       cnt_q,          cnt_d;
   logic             in_ready_q,     in_ready_d;
   logic             busy_q,         busy_d;
   logic [WIDTH-1:0] hold_data_q,    hold_data_d;
   logic [15:0]      launch_count_q, launch_count_d;

   logic accept;
   logic is_dup;

   assign accept = bus.in_valid & in_ready_q;

`ifdef CDC_SRC_HOLD_SKIP_DUP_EN
   // The crossing already carries this value, so there is nothing to launch.
   assign is_dup = (bus.in_data == hold_data_q);
`else
   assign is_dup = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      in_ready_d     = in_ready_q;
      busy_d         = busy_q;
      hold_data_d    = hold_data_q;
      launch_count_d = launch_count_q;

      unique case (state_q)
         ST_IDLE: begin
            // Ready rises on the first edge after reset release and stays up in IDLE.
            in_ready_d = 1'b1;
            if (accept && !is_dup) begin
               hold_data_d    = bus.in_data;
               cnt_d          = CNT_RELOAD;
               in_ready_d     = 1'b0;
               busy_d         = 1'b1;
               launch_count_d = launch_count_q + 16'd1;
               state_d        = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               in_ready_d = 1'b1;
               busy_d     = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 8'd0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         hold_data_q    <= '0;
         launch_count_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         in_ready_q     <= in_ready_d;
         busy_q         <= busy_d;
         hold_data_q    <= hold_data_d;
         launch_count_q <= launch_count_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.busy         = busy_q;
   assign bus.hold_data    = hold_data_q;
   assign bus.launch_count = launch_count_q;

endmodule
